unidade_controle_mostra: RTL and testbench

Control unit for the next game experiment: each round starts by playing the stored sequence back on the LEDs, and then the player repeats it under a timeout. The block sequences the existing datapath: the address counter E, the limit counter L, the play register R, the sequence memory and the comparator. It also owns the display and timeout timers internally. The block sits beside the datapath in the top level, in place of the previous control unit.

---
 rtl/unidade_controle_mostra_pkg.sv | 35 +++
 rtl/unidade_controle_mostra_temporizador_uc.sv | 21 ++
 rtl/unidade_controle_mostra.sv | 163 ++++++++++++++++
 tb/tb_unidade_controle_mostra.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/unidade_controle_mostra_pkg.sv
// Shared definitions for the display-and-play control unit:
// state codes and default phase lengths.
package unidade_controle_mostra_pkg;

    typedef enum logic [3:0] {
        INICIAL          = 4'd0,
        INICIALIZA       = 4'd1,
        INICIA_SEQUENCIA = 4'd2,
        MOSTRA           = 4'd3,
        APAGA            = 4'd4,
        PROXIMO_MOSTRA   = 4'd5,
        FIM_MOSTRA       = 4'd6,
        ESPERA           = 4'd7,
        REGISTRA         = 4'd8,
        COMPARA          = 4'd9,
        PASSA            = 4'd10,
        ULTIMA_SEQUENCIA = 4'd11,
        ESGOTADO         = 4'd13,
        ERRO             = 4'd14,
        ACERTO           = 4'd15
    } estado_t;

    localparam int T_SHOW_DEFAULT    = 1000;
    localparam int T_GAP_DEFAULT     = 250;
    localparam int T_TIMEOUT_DEFAULT = 3000;

    // Largest of three phase lengths; sizes the shared timer.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return m;
    endfunction

endpackage

// File: rtl/unidade_controle_mostra_temporizador_uc.sv
// Saturating up-counter shared by the display and timeout phases.
module temporizador_uc #(
    parameter int WIDTH = 12
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             zera,
    input  logic             conta,
    output logic [WIDTH-1:0] valor
);

    // Clear on reset or phase change; count up and stick at all-ones.
    always_ff @(posedge clock) begin
        if (reset || zera) begin
            valor <= '0;
        end else if (conta && (valor != '1)) begin
            valor <= valor + WIDTH'(1);
        end
    end

endmodule

// File: rtl/unidade_controle_mostra.sv
// Control unit: plays the stored sequence on the LEDs, then collects
// the player's repetition under a per-play timeout.
//
// state             | meaning
// ------------------+-------------------------------------------------
// inicial (0)       | idle, counters held clear
// inicializa (1)    | clear L and R for a new game
// inicia_seq (2)    | clear E before replaying the sequence
// mostra (3)        | LEDs show memory[E] for T_SHOW cycles
// apaga (4)         | LEDs dark for T_GAP cycles
// proximo_mostra(5) | advance E to the next displayed entry
// fim_mostra (6)    | clear E before the player repeats the sequence
// espera (7)        | wait for a play, T_TIMEOUT cycles allowed
// registra (8)      | load the play into R
// compara (9)       | check R against memory[E]
// passa (10)        | correct, advance E for the next play
// ultima_seq (11)   | round complete, grow L or finish the game
// esgotado (13)     | timed out
// erro (14)         | wrong play
// acerto (15)       | game won
module unidade_controle_mostra
    import unidade_controle_mostra_pkg::*;
#(
    parameter int T_SHOW    = T_SHOW_DEFAULT,
    parameter int T_GAP     = T_GAP_DEFAULT,
    parameter int T_TIMEOUT = T_TIMEOUT_DEFAULT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       jogada,
    input  logic       igual,
    input  logic       enderecoIgualLimite,
    input  logic       fimL,
    output logic       zeraL,
    output logic       contaL,
    output logic       zeraE,
    output logic       contaE,
    output logic       zeraR,
    output logic       registraR,
    output logic       mostra_leds,
    output logic       acertou,
    output logic       errou,
    output logic       esgotou,
    output logic       pronto,
    output logic [3:0] db_estado
);

    localparam int TMAX = max3(T_SHOW, T_GAP, T_TIMEOUT);
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [TW-1:0] FIM_SHOW    = TW'(T_SHOW - 1);
    localparam logic [TW-1:0] FIM_GAP     = TW'(T_GAP - 1);
    localparam logic [TW-1:0] FIM_TIMEOUT = TW'(T_TIMEOUT - 1);

    estado_t       estado;
    estado_t       proximo;
    logic [TW-1:0] timer;
    logic          zera_timer;
    logic          conta_timer;

    // The timer restarts on every state change, so each phase starts at zero.
    assign zera_timer  = (proximo != estado);
    assign conta_timer = !zera_timer && (estado inside {MOSTRA, APAGA, ESPERA});

    temporizador_uc #(.WIDTH(TW)) u_temporizador (
        .clock (clock),
        .reset (reset),
        .zera  (zera_timer),
        .conta (conta_timer),
        .valor (timer)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado <= INICIAL;
        end else begin
            estado <= proximo;
        end
    end

    // Next-state logic; jogada wins over timeout in the terminal cycle.
    always_comb begin
        proximo = estado;
        case (estado)
            INICIAL:          if (iniciar) proximo = INICIALIZA;
            INICIALIZA:       proximo = INICIA_SEQUENCIA;
            INICIA_SEQUENCIA: proximo = MOSTRA;
            MOSTRA:           if (timer == FIM_SHOW) proximo = APAGA;
            APAGA: begin
                if (timer == FIM_GAP) begin
                    proximo = enderecoIgualLimite ? FIM_MOSTRA : PROXIMO_MOSTRA;
                end
            end
            PROXIMO_MOSTRA:   proximo = MOSTRA;
            FIM_MOSTRA:       proximo = ESPERA;
            ESPERA: begin
                if (jogada) begin
                    proximo = REGISTRA;
                end else if (timer == FIM_TIMEOUT) begin
                    proximo = ESGOTADO;
                end
            end
            REGISTRA:         proximo = COMPARA;
            COMPARA: begin
                if (!igual) begin
                    proximo = ERRO;
                end else if (enderecoIgualLimite) begin
                    proximo = ULTIMA_SEQUENCIA;
                end else begin
                    proximo = PASSA;
                end
            end
            PASSA:            proximo = ESPERA;
            ULTIMA_SEQUENCIA: proximo = fimL ? ACERTO : INICIA_SEQUENCIA;
            ESGOTADO, ERRO, ACERTO: if (iniciar) proximo = INICIALIZA;
            default:          proximo = INICIAL;
        endcase
    end

    // Moore output decode.
    always_comb begin
        zeraL       = 1'b0;
        contaL      = 1'b0;
        zeraE       = 1'b0;
        contaE      = 1'b0;
        zeraR       = 1'b0;
        registraR   = 1'b0;
        mostra_leds = 1'b0;
        acertou     = 1'b0;
        errou       = 1'b0;
        esgotou     = 1'b0;
        pronto      = 1'b0;
        case (estado)
            INICIAL, INICIALIZA: begin
                zeraL = 1'b1;
                zeraR = 1'b1;
            end
            INICIA_SEQUENCIA, FIM_MOSTRA: zeraE = 1'b1;
            PROXIMO_MOSTRA, PASSA:        contaE = 1'b1;
            ULTIMA_SEQUENCIA:             contaL = 1'b1;
            REGISTRA:                     registraR = 1'b1;
            MOSTRA:                       mostra_leds = 1'b1;
            ACERTO: begin
                acertou = 1'b1;
                pronto  = 1'b1;
            end
            ERRO: begin
                errou  = 1'b1;
                pronto = 1'b1;
            end
            ESGOTADO: begin
                esgotou = 1'b1;
                pronto  = 1'b1;
            end
            default: ;
        endcase
    end

    assign db_estado = estado;

endmodule

// File: tb/tb_unidade_controle_mostra.sv
// Bench for unidade_controle_mostra with short phase lengths.
module tb_unidade_controle_mostra;

    localparam int TS = 4;
    localparam int TG = 2;
    localparam int TT = 8;

    logic clock, reset, iniciar, jogada, igual, eil, fimL;
    logic zeraL, contaL, zeraE, contaE, zeraR, registraR, mostra_leds;
    logic acertou, errou, esgotou, pronto;
    logic [3:0] db_estado;

    int tests = 0;
    int fails = 0;

    unidade_controle_mostra #(.T_SHOW(TS), .T_GAP(TG), .T_TIMEOUT(TT)) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .jogada(jogada),
        .igual(igual), .enderecoIgualLimite(eil), .fimL(fimL),
        .zeraL(zeraL), .contaL(contaL), .zeraE(zeraE), .contaE(contaE),
        .zeraR(zeraR), .registraR(registraR), .mostra_leds(mostra_leds),
        .acertou(acertou), .errou(errou), .esgotou(esgotou), .pronto(pronto),
        .db_estado(db_estado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: state plus number of cycles spent in it so far (1 on entry).
    int m_state = 0;
    int m_dwell = 0;
    bit m_valid = 0;

    function automatic int model_next(input int s, input int dwell);
        case (s)
            0:  return iniciar ? 1 : 0;
            1:  return 2;
            2:  return 3;
            3:  return (dwell == TS) ? 4 : 3;
            4:  return (dwell == TG) ? (eil ? 6 : 5) : 4;
            5:  return 3;
            6:  return 7;
            7:  return jogada ? 8 : ((dwell == TT) ? 13 : 7);
            8:  return 9;
            9:  return !igual ? 14 : (eil ? 11 : 10);
            10: return 7;
            11: return fimL ? 15 : 2;
            13, 14, 15: return iniciar ? 1 : s;
            default: return 0;
        endcase
    endfunction

    // {db_estado, zeraL, contaL, zeraE, contaE, zeraR, registraR, leds, acertou, errou, esgotou, pronto}
    function automatic logic [14:0] model_out(input int s);
        logic [14:0] o;
        o = '0;
        o[14:11] = 4'(s);
        o[10] = (s == 0 || s == 1);
        o[9]  = (s == 11);
        o[8]  = (s == 2 || s == 6);
        o[7]  = (s == 5 || s == 10);
        o[6]  = (s == 0 || s == 1);
        o[5]  = (s == 8);
        o[4]  = (s == 3);
        o[3]  = (s == 15);
        o[2]  = (s == 14);
        o[1]  = (s == 13);
        o[0]  = (s == 13 || s == 14 || s == 15);
        return o;
    endfunction

    // Advance the model on each rising edge.
    always @(posedge clock) begin
        int nxt;
        if (reset) begin
            m_state = 0;
            m_dwell = 1;
            m_valid = 1;
        end else if (m_valid) begin
            nxt = model_next(m_state, m_dwell);
            m_dwell = (nxt == m_state) ? m_dwell + 1 : 1;
            m_state = nxt;
        end
    end

    // Compare every output against the model on the falling edge.
    always @(negedge clock) begin
        logic [14:0] got, exp;
        if (m_valid) begin
            exp = model_out(m_state);
            got = {db_estado, zeraL, contaL, zeraE, contaE, zeraR, registraR,
                   mostra_leds, acertou, errou, esgotou, pronto};
            tests++;
            if (got !== exp) begin
                fails++;
                $display("FAIL outputs: got %b expected %b (model state %0d) at %0t",
                         got, exp, m_state, $time);
            end
        end
    end

    task automatic wait_state(input int target, input int budget);
        int n;
        n = 0;
        while (db_estado != 4'(target) && n < budget) begin
            @(negedge clock);
            n++;
        end
        check("wait_state", db_estado, target);
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    initial begin
        int seq0 [10];
        int leds, cycles, ce, cl;
        seq0 = '{1, 2, 3, 3, 3, 3, 4, 4, 6, 7};
        reset = 1; iniciar = 0; jogada = 0; igual = 0; eil = 0; fimL = 0;
        repeat (2) tick();
        reset = 0;

        check("reset_estado", db_estado, 0);
        check("reset_zeraL", zeraL, 1);
        check("reset_zeraR", zeraR, 1);
        check("reset_leds", mostra_leds, 0);
        check("reset_pronto", pronto, 0);

        // Round 0, single entry.
        eil = 1; iniciar = 1; leds = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            iniciar = 0;
            check("round0_seq", db_estado, seq0[i]);
            leds += int'(mostra_leds);
        end
        check("round0_leds", leds, TS);

        // Timeout with no play.
        for (int i = 1; i < TT; i++) begin
            tick();
            check("espera_hold", db_estado, 7);
        end
        tick();
        check("timeout_estado", db_estado, 13);
        check("timeout_esgotou", esgotou, 1);
        check("timeout_pronto", pronto, 1);
        check("timeout_errou", errou, 0);

        // Play in the terminal cycle, then a wrong play.
        iniciar = 1; tick(); iniciar = 0;
        check("restart_estado", db_estado, 1);
        wait_state(7, 40);
        repeat (TT - 1) tick();
        jogada = 1; tick(); jogada = 0;
        check("terminal_jogada", db_estado, 8);
        igual = 0;
        tick(); check("compara", db_estado, 9);
        tick(); check("erro_estado", db_estado, 14);
        check("erro_errou", errou, 1);
        check("erro_pronto", pronto, 1);
        jogada = 1; tick(); jogada = 0;
        check("erro_holds", db_estado, 14);
        iniciar = 1; tick(); iniciar = 0;
        check("erro_restart", db_estado, 1);
        check("erro_restart_zeraL", zeraL, 1);
        check("erro_restart_zeraR", zeraR, 1);

        // Two-entry display.
        eil = 0;
        tick();
        check("two_start", db_estado, 2);
        cycles = 1; leds = 0; ce = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (db_estado == 4'd7) break;
            cycles++;
            leds += int'(mostra_leds);
            ce += int'(contaE);
            if (db_estado == 4'd5) eil = 1;
        end
        check("two_reach_espera", db_estado, 7);
        check("two_cycles", cycles, 15);
        check("two_leds", leds, 2 * TS);
        check("two_contaE", ce, 1);

        // Correct last play with fimL=0 replays the display.
        jogada = 1; igual = 1; eil = 1; fimL = 0;
        tick(); jogada = 0;
        check("replay_registra", db_estado, 8);
        tick(); check("replay_compara", db_estado, 9);
        tick(); check("replay_ultima", db_estado, 11);
        tick(); check("replay_inicia", db_estado, 2);
        wait_state(7, 40);

        // Correct non-last play goes through passa.
        jogada = 1; eil = 0;
        tick(); jogada = 0;
        check("passa_registra", db_estado, 8);
        tick(); check("passa_compara", db_estado, 9);
        tick(); check("passa_estado", db_estado, 10);
        tick(); check("passa_espera", db_estado, 7);
        repeat (5) tick();

        // Win.
        jogada = 1; eil = 1; fimL = 1; cl = 0;
        tick(); jogada = 0;
        check("win_registra", db_estado, 8);
        cl += int'(contaL);
        tick(); check("win_compara", db_estado, 9); cl += int'(contaL);
        tick(); check("win_ultima", db_estado, 11); cl += int'(contaL);
        tick(); check("win_acerto", db_estado, 15); cl += int'(contaL);
        check("win_contaL", cl, 1);
        check("win_acertou", acertou, 1);
        check("win_pronto", pronto, 1);

        // Reset during mostra.
        iniciar = 1; tick(); iniciar = 0;
        wait_state(3, 10);
        tick();
        reset = 1; tick(); reset = 0;
        check("rst_mostra_estado", db_estado, 0);
        check("rst_mostra_leds", mostra_leds, 0);
        check("rst_mostra_zeraL", zeraL, 1);
        check("rst_mostra_zeraE", zeraE, 0);
        check("rst_mostra_contaE", contaE, 0);

        // Reset during espera, then a full timeout window.
        iniciar = 1; tick(); iniciar = 0;
        wait_state(7, 40);
        repeat (3) tick();
        reset = 1; tick(); reset = 0;
        check("rst_espera_estado", db_estado, 0);
        check("rst_espera_zeraR", zeraR, 1);
        check("rst_espera_registraR", registraR, 0);
        iniciar = 1; tick(); iniciar = 0;
        tick(); jogada = 1; tick(); jogada = 0;
        wait_state(7, 40);
        for (int i = 1; i < TT; i++) begin
            tick();
            check("post_rst_hold", db_estado, 7);
        end
        tick();
        check("post_rst_timeout", db_estado, 13);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
